// File: rtl/soc_region_table.sv
// Programmable SoC address map: NrRegions {base, length, attr} entries with
// per-entry lock, a single-cycle config port and a 2-stage lookup pipeline.
module soc_region_table #(
  parameter int NrRegions = 10,
  parameter int AddrWidth = 64,
  parameter logic [AddrWidth-1:0] DefaultBase [NrRegions] = '{
    64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_3000_0000,
    64'h0000_0000_2000_0000, 64'h0000_0000_1800_0000, 64'h0000_0000_1000_0000,
    64'h0000_0000_0C00_0000, 64'h0000_0000_0200_0000, 64'h0000_0000_0001_0000,
    64'h0000_0000_0000_0000},
  parameter logic [AddrWidth-1:0] DefaultLength [NrRegions] = '{
    64'h0000_0000_4000_0000, 64'h0000_0000_0000_1000, 64'h0000_0000_0001_0000,
    64'h0000_0000_0080_0000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000,
    64'h0000_0000_03FF_FFFF, 64'h0000_0000_000C_0000, 64'h0000_0000_0001_0000,
    64'h0000_0000_0000_1000},
  parameter logic [7:0] DefaultAttr [NrRegions] = '{
    8'h0B, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0B, 8'h0B},
  localparam int IdxW = $clog2(NrRegions)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxW+1:0]      cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxW-1:0]      resp_idx_o,
  output logic [3:0]           resp_attr_o
);

  localparam logic [IdxW:0] NrRegL = (IdxW+1)'(NrRegions);

  logic [AddrWidth-1:0] base_q [NrRegions];
  logic [AddrWidth-1:0] len_q  [NrRegions];
  logic [7:0]           attr_q [NrRegions];

  // ---------------- config port ----------------
  logic [IdxW-1:0]      cfg_idx;
  logic [1:0]           cfg_field;
  logic                 sel_lock;
  logic [AddrWidth-1:0] sel_rdata;
  logic                 cfg_err;
  logic                 cfg_wr;

  assign cfg_idx   = cfg_addr_i[IdxW+1:2];
  assign cfg_field = cfg_addr_i[1:0];

  always_comb begin
    sel_lock  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NrRegions; i++) begin
      if (cfg_idx == IdxW'(i)) begin
        sel_lock = attr_q[i][7];
        case (cfg_field)
          2'd0:    sel_rdata = base_q[i];
          2'd1:    sel_rdata = len_q[i];
          2'd2:    sel_rdata = AddrWidth'(attr_q[i]);
          default: sel_rdata = '0;
        endcase
      end
    end
  end

  // A locked entry rejects every write, so lock can only be cleared by reset.
  assign cfg_err = ({1'b0, cfg_idx} >= NrRegL) || (cfg_field == 2'd3) ||
                   (cfg_we_i && sel_lock);
  assign cfg_wr  = cfg_req_i && cfg_we_i && !cfg_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRegions; i++) begin
        base_q[i] <= DefaultBase[i];
        len_q[i]  <= DefaultLength[i];
        attr_q[i] <= {DefaultAttr[i][7], 3'b000, DefaultAttr[i][3:0]};
      end
    end else if (cfg_wr) begin
      for (int i = 0; i < NrRegions; i++) begin
        if (cfg_idx == IdxW'(i)) begin
          case (cfg_field)
            2'd0:    base_q[i] <= cfg_wdata_i;
            2'd1:    len_q[i]  <= cfg_wdata_i;
            2'd2:    attr_q[i] <= {cfg_wdata_i[7], 3'b000, cfg_wdata_i[3:0]};
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i && cfg_err;
      cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !cfg_err) ? sel_rdata : '0;
    end
  end

  // ---------------- lookup pipeline ----------------
  // Handshake: a request transfers on a cycle with req_valid_i && req_ready_o;
  // a response transfers on resp_valid_o && resp_ready_i, and resp_* hold
  // steady until then. Both stages move together whenever the output drains.
  logic                       advance;
  logic [NrRegions-1:0]       hit_vec;
  logic                       s1_valid;
  logic [NrRegions-1:0]       s1_hit;
  logic [NrRegions-1:0][3:0]  s1_attr;
  logic                       enc_hit;
  logic [IdxW-1:0]            enc_idx;
  logic [3:0]                 enc_attr;

  assign advance     = !resp_valid_o || resp_ready_i;
  assign req_ready_o = advance;

  // The addr >= base term stops a region near the top from wrapping to 0.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NrRegions; i++) begin
      hit_vec[i] = attr_q[i][0] && (req_addr_i >= base_q[i]) &&
                   ((req_addr_i - base_q[i]) < len_q[i]);
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    enc_hit  = 1'b0;
    enc_idx  = '0;
    enc_attr = '0;
    for (int i = NrRegions - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        enc_hit  = 1'b1;
        enc_idx  = IdxW'(i);
        enc_attr = s1_attr[i];
      end
    end
  end

  // Attributes are snapshotted in stage 1 so a later config write cannot
  // change a lookup that is already in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid     <= 1'b0;
      s1_hit       <= '0;
      s1_attr      <= '0;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_idx_o   <= '0;
      resp_attr_o  <= '0;
    end else if (advance) begin
      s1_valid <= req_valid_i;
      s1_hit   <= req_valid_i ? hit_vec : '0;
      for (int i = 0; i < NrRegions; i++) begin
        s1_attr[i] <= attr_q[i][3:0];
      end
      resp_valid_o <= s1_valid;
      resp_hit_o   <= enc_hit;
      resp_idx_o   <= enc_idx;
      resp_attr_o  <= enc_attr;
    end
  end

endmodule

// File: doc/soc_region_table.md
Name: soc_region_table

Overview:
- Runtime-programmable address-map and attribute table for the SoC interconnect and core PMA checks.
- Holds NrRegions {base, length, attributes} entries. Reset contents come from parameters, so the default map matches the fixed SoC map.
- Software can reprogram entries through a simple register port, with a per-entry lock.
- A 2-stage pipelined lookup port returns the hit region index and its attributes for an address, with valid/ready backpressure.

Parameters:
- NrRegions, 10, number of table entries; index width IdxW = $clog2(NrRegions).
- AddrWidth, 64, width of lookup address, base and length.
- DefaultBase, {DRAM 0x8000_0000, GPIO 0x4000_0000, Ethernet 0x3000_0000, SPI 0x2000_0000, Timer 0x1800_0000, UART 0x1000_0000, PLIC 0x0C00_0000, CLINT 0x0200_0000, ROM 0x1_0000, Debug 0x0}, reset base per entry; index 0 = DRAM.
- DefaultLength, {0x4000_0000, 0x1000, 0x1_0000, 0x80_0000, 0x1000, 0x1000, 0x3FF_FFFF, 0xC_0000, 0x1_0000, 0x1000}, reset length per entry.
- DefaultAttr, see Behaviour, reset attribute byte per entry.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- cfg_req_i, in, 1, config access strobe; single-cycle, always accepted.
- cfg_we_i, in, 1, 1 = write, 0 = read.
- cfg_addr_i, in, IdxW+2, {entry index, field}: field 0 = base, 1 = length, 2 = attr, 3 = reserved.
- cfg_wdata_i, in, AddrWidth, write data.
- cfg_rvalid_o, out, 1, response valid, one cycle after every cfg_req_i.
- cfg_rdata_o, out, AddrWidth, read data; 0 on writes and errors.
- cfg_err_o, out, 1, error flag, valid with cfg_rvalid_o.
- req_valid_i, in, 1, lookup request valid.
- req_ready_o, out, 1, lookup request ready.
- req_addr_i, in, AddrWidth, lookup address.
- resp_valid_o, out, 1, lookup result valid.
- resp_ready_i, in, 1, consumer ready.
- resp_hit_o, out, 1, some valid entry matched.
- resp_idx_o, out, IdxW, matching entry; 0 if miss.
- resp_attr_o, out, 4, {idempotent, cached, exec, valid} of the hit; 0 if miss.

Behaviour:
- Attribute byte layout:
  - bit0 valid, bit1 exec, bit2 cached, bit3 idempotent, bit7 lock; bits 6:4 read as 0.
  - DefaultAttr: DRAM, ROM, Debug = 0x0B; all other entries = 0x01; no entry locked at reset.
- Reset:
  - Table reloads from the Default* parameters.
  - Both pipeline stages invalid.
  - All outputs 0 except req_ready_o = 1.
  - A lookup in flight is discarded.
- Match rule for entry i:
  - valid = 1, and (addr - base) computed unsigned modulo 2^AddrWidth is < length.
  - length = 0 never matches. Base near the top of the address space must not alias through the wrap.
- Priority: the lowest matching index wins. The 4-bit resp_attr_o excludes lock.
- Lookup pipeline:
  - Stage 1 registers the per-entry hit vector.
  - Stage 2 registers the priority-encoded index and attributes.
  - Latency is exactly 2 cycles from handshake to resp_valid_o when unstalled; throughput is 1/cycle.
- Backpressure:
  - advance = !resp_valid_o || resp_ready_i, and req_ready_o = advance.
  - Both stages hold while stalled.
  - resp_* must stay stable while resp_valid_o && !resp_ready_i.
- Config write at cycle T:
  - Table updates at the edge ending T.
  - A lookup accepted in cycle T uses the old contents; one accepted in T+1 uses the new.
  - Lookups already in stage 1/2 are not re-evaluated.
- Config errors (cfg_err_o = 1, table unchanged):
  - Entry index >= NrRegions.
  - Field 3.
  - Any write to an entry whose lock bit is 1.
- Lock is sticky: a write setting bit7 locks that entry, including the same write's base/length/attr field. Only rst_i clears it.
- Config reads return the current register value, including lock, at T+1.
- Config and lookup ports are independent; simultaneous activity is legal.

Test Plan:
- Reset, then lookups 0x8000_1000, 0x1000_0010, 0x0000_0800, 0x5000_0000 -> idx 0 attr 0xB; idx 5 attr 0x1; idx 9 attr 0xB; miss with idx 0 attr 0. Each response arrives exactly 2 cycles after its handshake.
- Overlap: write entry 3 base 0x8000_0000, length 0x1000 -> lookup 0x8000_0800 returns idx 0, because lowest index wins. Clear entry 0 valid (attr 0x0A) -> same lookup returns idx 3 attr 0x1.
- Lock: write entry 1 attr 0x81, then write entry 1 base 0x0 -> second write cfg_err_o = 1; read base = 0x4000_0000, read attr = 0x81. Assert rst_i -> attr reads 0x01 and writes succeed again.
- Wrap: entry 2 base 0xFFFF_FFFF_FFFF_F000, length 0x2000 -> address 0x0 misses entry 2; address 0xFFFF_FFFF_FFFF_FFF0 hits idx 2. Length 0 on entry 4 -> 0x1800_0000 misses.
- Backpressure: stream 4 back-to-back lookups with resp_ready_i low for 3 cycles -> req_ready_o drops, held response is stable, no loss or reorder. Write to entry 5 in the same cycle a lookup of 0x1000_0000 is accepted -> that lookup sees the old value.
- Errors and reset: cfg_addr_i index 12, or field 3 -> cfg_err_o = 1 and rdata 0. Assert rst_i with both pipeline stages full -> resp_valid_o = 0 the next cycle.
